// File: rtl/coeff_level_serializer_pkg.sv
// -----------------------------------------------------------------------------
// coeff_level_serializer_pkg
// Shared definitions for the coefficient level serializer: block geometry,
// magnitude clamp limit, the zigzag packing convention for a block of levels,
// the serializer FSM state encoding and the magnitude/clamp helper.
// -----------------------------------------------------------------------------
package coeff_level_serializer_pkg;

  localparam int BLOCK_SIZE = 4;
  localparam int N_COEFF    = BLOCK_SIZE * BLOCK_SIZE;
  localparam int LEVEL_W    = 16;
  localparam int POS_W      = $clog2(N_COEFF);
  localparam int CNT_W      = $clog2(N_COEFF + 1);
  localparam int MAG_W      = 11;
  localparam int MAX_LEVEL  = 2047;

  typedef logic signed [LEVEL_W-1:0] level_t;

  // Zigzag packing convention shared with the quantizer: element n of the
  // packed vector is the n-th coefficient in zigzag scan order, which places
  // it at bits [16n+15:16n] of the flat bus.
  typedef level_t [N_COEFF-1:0] level_vec_t;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_e;

  // |v| clamped to MAX_LEVEL. The absolute value is formed one bit wider than
  // the level so that -32768 becomes +32768 instead of wrapping negative.
  function automatic mag_t clamp_mag(input level_t v);
    logic signed [LEVEL_W:0] ext;
    logic        [LEVEL_W:0] abs_v;
    ext   = {v[LEVEL_W-1], v};
    abs_v = ext[LEVEL_W] ? $unsigned(-ext) : $unsigned(ext);
    if (abs_v >= (LEVEL_W + 1)'(MAX_LEVEL)) begin
      return MAG_W'(MAX_LEVEL);
    end
    return abs_v[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/coeff_level_serializer_if.sv
// -----------------------------------------------------------------------------
// coeff_level_serializer_if
// Bundle of the serializer's block-capture and coefficient-stream signals.
//   start/levels/in_ready : block capture from the reconstruct stage
//   out_*                 : one coefficient word per valid/ready handshake
//   nz_count/empty/done   : per-block summary, done is a one-cycle pulse
// Modports: slave = the serializer, master = the environment driving it.
// -----------------------------------------------------------------------------
interface coeff_level_serializer_if;
  import coeff_level_serializer_pkg::*;

  logic       start;
  level_vec_t levels;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  pos_t       out_pos;
  mag_t       out_mag;
  logic       out_sign;
  logic       out_last;
  cnt_t       nz_count;
  logic       empty;
  logic       done;

  modport slave (
    input  start, levels, out_ready,
    output in_ready, out_valid, out_pos, out_mag, out_sign, out_last,
           nz_count, empty, done
  );

  modport master (
    output start, levels, out_ready,
    input  in_ready, out_valid, out_pos, out_mag, out_sign, out_last,
           nz_count, empty, done
  );

endinterface

// File: rtl/coeff_level_serializer_last_nz_finder.sv
// -----------------------------------------------------------------------------
// last_nz_finder
// Combinational scan of one block of levels. Indices below FIRST are masked.
//   levels   : block of levels in zigzag order
//   last     : highest unmasked index holding a non-zero level (0 if none)
//   empty    : no unmasked non-zero level
//   nz_count : number of unmasked non-zero levels
// -----------------------------------------------------------------------------
module last_nz_finder
  import coeff_level_serializer_pkg::*;
#(
  parameter int FIRST = 0
) (
  input  level_vec_t levels,
  output pos_t       last,
  output logic       empty,
  output cnt_t       nz_count
);

  // Ascending scan: the final hit overwrites earlier ones, which makes the
  // highest non-zero index win.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    last     = '0;
    empty    = 1'b1;
    nz_count = '0;
    for (int n = 0; n < N_COEFF; n++) begin
      if (n >= FIRST && levels[n] != '0) begin
        last     = pos_t'(n);
        empty    = 1'b0;
        nz_count = nz_count + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/coeff_level_serializer.sv
// -----------------------------------------------------------------------------
// coeff_level_serializer
// Captures one block of quantized levels, locates the last non-zero
// coefficient and streams coefficients FIRST..last as clamped magnitude, sign,
// zigzag position and end flag, one per handshake. Reports the non-zero count
// and an empty-block flag, and pulses done once per block.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : capture, coefficient stream and summary (see the interface)
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module coeff_level_serializer
  import coeff_level_serializer_pkg::*;
#(
  parameter int FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  coeff_level_serializer_if.slave   bus
);

  state_e     state_q, state_d;
  level_vec_t buf_q, buf_d;
  pos_t       ptr_q, ptr_d;
  pos_t       last_q, last_d;
  cnt_t       nz_count_q, nz_count_d;
  logic       empty_q, empty_d;

  pos_t       scan_last;
  logic       scan_empty;
  cnt_t       scan_nz;

  // Scans the captured buffer; its results are only registered in SCAN.
  last_nz_finder #(.FIRST(FIRST)) u_finder (
    .levels   (buf_q),
    .last     (scan_last),
    .empty    (scan_empty),
    .nz_count (scan_nz)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the level buffer is a register bank, not a RAM, so it can and
      // does take the reset; a block in flight is discarded on reset.
      state_q    <= IDLE;
      buf_q      <= '0;
      ptr_q      <= '0;
      last_q     <= '0;
      nz_count_q <= '0;
      empty_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      buf_q      <= buf_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      nz_count_q <= nz_count_d;
      empty_q    <= empty_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    nz_count_d = nz_count_q;
    empty_d    = empty_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          buf_d   = bus.levels;
          state_d = SCAN;
        end
      end
      SCAN: begin
        last_d     = scan_last;
        nz_count_d = scan_nz;
        empty_d    = scan_empty;
        if (scan_empty) begin
          state_d = FIN;
        end else begin
          ptr_d   = pos_t'(FIRST);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (ptr_q == last_q) state_d = FIN;
          else                 ptr_d   = ptr_q + pos_t'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. The coefficient word is forced to zero outside EMIT so
  // that the stream fields are quiet whenever out_valid is low.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == EMIT);
    bus.done      = (state_q == FIN);
    bus.nz_count  = nz_count_q;
    bus.empty     = empty_q;
    bus.out_pos   = '0;
    bus.out_mag   = '0;
    bus.out_sign  = 1'b0;
    bus.out_last  = 1'b0;
    if (state_q == EMIT) begin
      bus.out_pos  = ptr_q;
      bus.out_mag  = clamp_mag(buf_q[ptr_q]);
      bus.out_sign = buf_q[ptr_q][LEVEL_W-1];
      bus.out_last = (ptr_q == last_q);
    end
  end

endmodule
